ysyx_24070016_ifu: RTL and testbench
====================================

# ysyx_24070016_ifu

Instruction fetch unit for the ysyx_24070016 multi-cycle RV32 core. It produces the 32-bit instruction word and its PC consumed by the decode stage, and is the producer side of the decoder's `inst` input. It owns the architectural PC and fetches one instruction at a time from instruction memory over a valid/ready request channel. It then holds the word until decode accepts it, and waits for the next-PC from the execute/writeback path before fetching again.

## Interface
- `RESET_PC`, default 32'h8000_0000: PC loaded by reset; first fetch address.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `imem_req_valid`  out  1  fetch request valid.
- `imem_req_ready`  in  1  memory accepts request.
- `imem_req_addr`  out  32  fetch address (= current PC).
- `imem_resp_valid`  in  1  response data valid (single-cycle pulse).
- `imem_resp_data`  in  32  fetched instruction word.
- `imem_resp_err`  in  1  access error, qualified by `imem_resp_valid`.
- `inst_valid`  out  1  instruction available to decode.
- `inst_ready`  in  1  decode accepts instruction.
- `inst`  out  32  instruction word to decode.
- `inst_pc`  out  32  PC of `inst`.
- `npc_valid`  in  1  next-PC valid from execute/writeback.
- `npc`  in  32  next PC (sequential, branch or jump target).
- `fetch_fault`  out  1  sticky fetch fault; core halts.

## Operation
- State machine states: IDLE, REQ, WAIT, DELIVER, WAIT_NPC, FAULT. Reset state is IDLE.
- IDLE: unconditionally moves to REQ on the next cycle.
- REQ: drive `imem_req_valid`=1 with `imem_req_addr`=PC. Hold both stable until `imem_req_ready`. On `valid & ready`, go to WAIT.
- WAIT: on `imem_resp_valid` with `imem_resp_err`=0, latch `imem_resp_data` into `inst`, latch PC into `inst_pc`, and go to DELIVER. With `imem_resp_err`=1, set `fetch_fault` and go to FAULT.
- DELIVER: `inst_valid`=1. `inst` and `inst_pc` stay stable. On `inst_valid & inst_ready`, go to WAIT_NPC.
- WAIT_NPC: on `npc_valid`, load PC with `npc` and go to REQ.
- FAULT: terminal until reset. All handshake outputs are 0 and `fetch_fault`=1.
- `imem_resp_valid` outside WAIT is ignored. `npc_valid` outside WAIT_NPC is ignored; PC is unchanged.
- `imem_req_ready` in WAIT is a don't-care. The response may arrive no earlier than the cycle after acceptance.
- PC is 32-bit with no arithmetic in this block; npc wrap-around (e.g. 32'hFFFF_FFFC+4=0) is computed upstream and accepted as given.
- Reset mid-operation: state returns to IDLE, PC=RESET_PC, and any outstanding request is abandoned. Instruction memory must be reset by the same `rst`.

## Timing
- Reset values: `imem_req_valid`=0, `imem_req_addr`=RESET_PC, `inst_valid`=0, `inst`=32'h0000_0013 (nop), `inst_pc`=RESET_PC, `fetch_fault`=0.
- All outputs are driven from registers or decoded directly from the state register. There is no combinational path from any input to any output.
- First `imem_req_valid` is asserted in cycle 1 after `rst` deasserts.
- Response in cycle N gives `inst_valid`=1 in cycle N+1.
- Accept in cycle N (`inst_valid & inst_ready`) gives `inst_valid`=0 in cycle N+1.
- `npc_valid` in cycle N gives `imem_req_valid`=1 with the new address in cycle N+1.
- Minimum throughput is 4 cycles per instruction: REQ, WAIT, DELIVER, WAIT_NPC, each 1 cycle with zero-wait partners.

## Configuration
- `YSYX_24070016_IFU_ALIGN_CHECK_EN`
  - Defined: the check applies to RESET_PC and every `npc` loaded. If `PC[1:0]`≠0 when entering REQ, no request is issued; the block goes straight to FAULT with `fetch_fault`=1 in the following cycle.
  - Undefined: no check is made, and `PC[1:0]` passes to `imem_req_addr` unmodified.

## Test plan
- Reset release with zero-wait memory, `inst_ready`=1, and `npc`=pc+4 returned 1 cycle after accept → requests to 0x80000000, 0x80000004, 0x80000008 at cycles 1, 5, 9. `inst`/`inst_pc` match the memory image.
- `imem_req_ready` held low 3 cycles → `imem_req_valid` and addr 0x80000000 held stable for 4 cycles, and there is exactly one accepted request.
- `inst_ready` low 5 cycles in DELIVER → `inst_valid`=1 with `inst`/`inst_pc` constant. A stray `npc_valid`=1 with `npc`=0x1234 during this window leaves the next fetch at the later-supplied npc.
- `imem_resp_err`=1 on second fetch → `fetch_fault`=1 the next cycle, and no further `imem_req_valid` or `inst_valid` until `rst`.
- `rst` pulsed while in WAIT → all outputs at reset values asynchronously, then the fetch restarts at RESET_PC.
- With the macro defined, `npc`=0x80000006 → no request and `fetch_fault`=1. Without the macro → request issued to 0x80000006.

Source files
------------

// File: rtl/ysyx_24070016_ifu.sv
// rtl/ysyx_24070016_ifu.sv - instruction fetch unit: owns the PC, fetches one word, hands it to decode
// Optional PC alignment check enabled by defining YSYX_24070016_IFU_ALIGN_CHECK_EN
module ysyx_24070016_ifu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        imem_resp_err,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        npc_valid,
    input  logic [31:0] npc,
    output logic        fetch_fault
);
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DELIVER,
        S_WAIT_NPC,
        S_FAULT
    } state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] inst_q;
    logic [31:0] inst_pc_q;
    logic        reset_pc_bad;
    logic        npc_bad;

    // A misaligned PC diverts the transition into REQ straight to FAULT
`ifdef YSYX_24070016_IFU_ALIGN_CHECK_EN
    assign reset_pc_bad = (RESET_PC[1:0] != 2'b00);
    assign npc_bad      = (npc[1:0] != 2'b00);
`else
    assign reset_pc_bad = 1'b0;
    assign npc_bad      = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pc_q      <= RESET_PC;
            inst_q    <= NOP;
            inst_pc_q <= RESET_PC;
        end else begin
            case (state_q)
                S_IDLE: state_q <= reset_pc_bad ? S_FAULT : S_REQ;
                S_REQ: begin
                    if (imem_req_ready) state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (imem_resp_valid) begin
                        if (imem_resp_err) begin
                            state_q <= S_FAULT;
                        end else begin
                            inst_q    <= imem_resp_data;
                            inst_pc_q <= pc_q;
                            state_q   <= S_DELIVER;
                        end
                    end
                end
                S_DELIVER: begin
                    if (inst_ready) state_q <= S_WAIT_NPC;
                end
                S_WAIT_NPC: begin
                    if (npc_valid) begin
                        pc_q    <= npc;
                        state_q <= npc_bad ? S_FAULT : S_REQ;
                    end
                end
                S_FAULT: state_q <= S_FAULT;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign imem_req_valid = (state_q == S_REQ);
    assign imem_req_addr  = pc_q;
    assign inst_valid     = (state_q == S_DELIVER);
    assign inst           = inst_q;
    assign inst_pc        = inst_pc_q;
    assign fetch_fault    = (state_q == S_FAULT);

endmodule

// File: tb/tb_ysyx_24070016_ifu.sv
// tb/tb_ysyx_24070016_ifu.sv - scoreboard bench for ysyx_24070016_ifu
`timescale 1ns/1ps
module tb_ysyx_24070016_ifu;
    localparam logic [31:0] RESET_PC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        imem_resp_err;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        npc_valid;
    logic [31:0] npc;
    logic        fetch_fault;

    always #5 clk = ~clk;

    ysyx_24070016_ifu #(.RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data), .imem_resp_err(imem_resp_err),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
        .npc_valid(npc_valid), .npc(npc), .fetch_fault(fetch_fault)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc;
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_pc_q[$];
    int          req_cyc_q[$];

    bit          rand_mode   = 1'b0;
    bit          stray_en    = 1'b0;
    bit          force_en    = 1'b0;
    bit          long_resp   = 1'b0;
    logic [31:0] force_npc   = '0;
    int          err_on_resp = 0;
    int          err_cyc     = -1;
    int          npc_cyc     = -1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A5A_1234;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: timed out waiting at cycle %0d", name, cyc);
    endtask

    // Memory, decode and execute stand-ins; also the reference PC sequence
    initial begin : agent
        int          resp_cnt = -1;
        int          npc_cnt  = -1;
        int          resp_num = 0;
        logic [31:0] resp_addr = '0;
        logic [31:0] model_pc  = RESET_PC;
        logic [31:0] next_pc   = '0;
        imem_req_ready = 0; imem_resp_valid = 0; imem_resp_data = '0; imem_resp_err = 0;
        inst_ready = 0; npc_valid = 0; npc = '0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                resp_cnt = -1; npc_cnt = -1; resp_num = 0; model_pc = RESET_PC;
                imem_req_ready = 0; imem_resp_valid = 0; imem_resp_err = 0;
                inst_ready = 0; npc_valid = 0;
            end else begin
                imem_resp_valid = 0; imem_resp_err = 0; imem_resp_data = $urandom;
                if (resp_cnt == 0) begin
                    resp_num++;
                    imem_resp_valid = 1;
                    imem_resp_data  = mem_word(resp_addr);
                    if (resp_num == err_on_resp) begin
                        imem_resp_err = 1;
                        err_cyc = cyc;
                    end
                    resp_cnt = -1;
                end else if (resp_cnt > 0) begin
                    resp_cnt--;
                end else if (stray_en && $urandom_range(0, 5) == 0) begin
                    imem_resp_valid = 1;
                    imem_resp_err   = 1'($urandom_range(0, 1));
                end
                imem_req_ready = rand_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
                if (imem_req_valid && imem_req_ready) begin
                    resp_addr = imem_req_addr;
                    resp_cnt  = long_resp ? 6 : (rand_mode ? int'($urandom_range(0, 3)) : 0);
                end

                npc_valid = 0; npc = $urandom;
                if (npc_cnt == 0) begin
                    npc_valid = 1;
                    npc       = next_pc;
                    npc_cyc   = cyc;
                    model_pc  = next_pc;
                    exp_addr_q.push_back(next_pc);
                    exp_pc_q.push_back(next_pc);
                    npc_cnt = -1;
                end else if (npc_cnt > 0) begin
                    npc_cnt--;
                end else if (stray_en && $urandom_range(0, 4) == 0) begin
                    npc_valid = 1;
                    npc       = 32'h0000_1234;
                end
                inst_ready = rand_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
                if (inst_valid && inst_ready) begin
                    npc_cnt = rand_mode ? int'($urandom_range(0, 3)) : 0;
                    if (force_en) begin
                        next_pc  = force_npc;
                        force_en = 0;
                    end else if (rand_mode && $urandom_range(0, 7) == 0) begin
                        next_pc = $urandom;
                        next_pc[1:0] = 2'b00;
                    end else if (rand_mode && $urandom_range(0, 15) == 0) begin
                        next_pc = 32'hFFFF_FFFC;
                    end else begin
                        next_pc = model_pc + 32'd4;
                    end
                end
            end
        end
    end

    initial begin : monitor
        bit          prev_req = 0;
        bit          prev_inst = 0;
        logic [31:0] prev_addr = '0;
        logic [31:0] prev_word = '0;
        logic [31:0] prev_pc = '0;
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_req = 0; prev_inst = 0;
            end else begin
                if (prev_req) begin
                    check("req_valid_hold", {31'd0, imem_req_valid}, 32'd1);
                    check("req_addr_hold", imem_req_addr, prev_addr);
                end
                if (prev_inst) begin
                    check("inst_valid_hold", {31'd0, inst_valid}, 32'd1);
                    check("inst_hold", inst, prev_word);
                    check("inst_pc_hold", inst_pc, prev_pc);
                end
                if (imem_req_valid && imem_req_ready) begin
                    req_cyc_q.push_back(cyc);
                    if (exp_addr_q.size() == 0) begin
                        timeout("req_unexpected");
                    end else begin
                        e = exp_addr_q.pop_front();
                        check("req_addr", imem_req_addr, e);
                    end
                end
                if (inst_valid && inst_ready) begin
                    if (exp_pc_q.size() == 0) begin
                        timeout("inst_unexpected");
                    end else begin
                        e = exp_pc_q.pop_front();
                        check("inst_pc", inst_pc, e);
                        check("inst_word", inst, mem_word(e));
                    end
                end
                prev_req  = imem_req_valid && !imem_req_ready;
                prev_addr = imem_req_addr;
                prev_inst = inst_valid && !inst_ready;
                prev_word = inst;
                prev_pc   = inst_pc;
            end
        end
    end

    task automatic check_reset(input string tag);
        check({tag, "_req_valid"}, {31'd0, imem_req_valid}, 32'd0);
        check({tag, "_req_addr"}, imem_req_addr, RESET_PC);
        check({tag, "_inst_valid"}, {31'd0, inst_valid}, 32'd0);
        check({tag, "_inst"}, inst, 32'h0000_0013);
        check({tag, "_inst_pc"}, inst_pc, RESET_PC);
        check({tag, "_fault"}, {31'd0, fetch_fault}, 32'd0);
    endtask

    task automatic assert_rst();
        rst = 1;
        exp_addr_q.delete(); exp_pc_q.delete(); req_cyc_q.delete();
        exp_addr_q.push_back(RESET_PC);
        exp_pc_q.push_back(RESET_PC);
        err_cyc = -1; npc_cyc = -1;
    endtask

    task automatic release_rst();
        repeat (2) @(posedge clk);
        #2;
        rst = 0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        assert_rst();
        release_rst();
    endtask

    task automatic wait_cyc(input int target, input string name);
        int t = 0;
        @(negedge clk);
        while (cyc < target && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (cyc != target) timeout(name);
    endtask

    initial begin : main
        int t;
        rst = 1;
        assert_rst();
        repeat (2) @(posedge clk);
        #2;
        check_reset("por");
        rst = 0;

        // Zero-wait partners: fetches at cycles 1, 5, 9
        do_reset();
        wait_cyc(12, "zero_wait_run");
        for (int i = 0; i < 3; i++)
            check($sformatf("req_cycle%0d", i),
                  (req_cyc_q.size() > i) ? req_cyc_q[i] : -1, 1 + 4 * i);

        rand_mode = 1; stray_en = 1;
        repeat (800) @(posedge clk);
        rand_mode = 0; stray_en = 0;

        // Asynchronous reset while a response is outstanding
        do_reset();
        long_resp = 1;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!(imem_req_valid && imem_req_ready) && t < 50);
        if (t >= 50) timeout("wait_req_accept");
        @(posedge clk);
        #3;
        assert_rst();
        #1;
        check_reset("async");
        long_resp = 0;
        release_rst();
        wait_cyc(6, "restart_run");
        check("restart_cycle", (req_cyc_q.size() > 0) ? req_cyc_q[0] : -1, 1);

        // Error on the second fetch
        err_on_resp = 2;
        do_reset();
        t = 0;
        while (err_cyc < 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (err_cyc < 0) timeout("wait_err_resp");
        else begin
            wait_cyc(err_cyc + 1, "fault_cycle");
            check("fault_set", {31'd0, fetch_fault}, 32'd1);
            t = 0;
            repeat (12) begin
                @(negedge clk);
                if (imem_req_valid || inst_valid || !fetch_fault) t++;
            end
            check("fault_quiet", t, 0);
        end
        err_on_resp = 0;

        // Misaligned next PC
        force_npc = 32'h8000_0006;
        force_en  = 1;
        do_reset();
        t = 0;
        while (npc_cyc < 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (npc_cyc < 0) timeout("wait_force_npc");
        else begin
            wait_cyc(npc_cyc + 1, "misalign_cycle");
`ifdef YSYX_24070016_IFU_ALIGN_CHECK_EN
            check("misalign_fault", {31'd0, fetch_fault}, 32'd1);
            check("misalign_no_req", {31'd0, imem_req_valid}, 32'd0);
`else
            check("misalign_req", {31'd0, imem_req_valid}, 32'd1);
            check("misalign_addr", imem_req_addr, 32'h8000_0006);
`endif
        end
        repeat (10) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
